// File: rtl/fact_ctrl_if.sv
// Handshake and datapath-strobe bundle between the factorial controller,
// its requester and the factorial datapath.
interface fact_ctrl_if #(
   parameter int SIZE = 8
);
   logic            go;
   logic [SIZE-1:0] n;
   logic            proceed;
   logic            sel_init;
   logic            cnt_load;
   logic            cnt_en;
   logic            reg_load;
   logic            done;
   logic            busy;
   logic            err;

   modport master (
      output go, n, proceed,
      input  sel_init, cnt_load, cnt_en, reg_load, done, busy, err
   );

   modport slave (
      input  go, n, proceed,
      output sel_init, cnt_load, cnt_en, reg_load, done, busy, err
   );
endinterface

// File: rtl/fact_ctrl.sv
// Factorial datapath controller: go/done handshake, overflow reject of n > MAX_N.
// Optional DP_CTRL_WDOG_EN aborts a LOOP whose proceed stays high too long.
module fact_ctrl #(
   parameter int SIZE       = 8,
   parameter int MAX_N      = 5,
   parameter int WDOG_LIMIT = 7
) (
   input logic         clk,
   input logic         rst,
   fact_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOOP, S_DONE, S_ERR} state_t;

   localparam logic [SIZE-1:0] MAX_N_V = MAX_N[SIZE-1:0];

   state_t state_q, state_d;
   logic   wdog_trip;
   logic   sel_init, cnt_load, cnt_en, reg_load, done, busy, err;

`ifdef DP_CTRL_WDOG_EN
   localparam int WW = $clog2(WDOG_LIMIT + 1);
   logic [WW-1:0] wdog_q;

   always_ff @(posedge clk) begin
      if (rst)                                             wdog_q <= '0;
      else if (state_q == S_INIT)                          wdog_q <= '0;
      else if (state_q == S_LOOP && wdog_q != WW'(WDOG_LIMIT)) wdog_q <= wdog_q + 1'b1;
   end

   // The WDOG_LIMIT-th LOOP cycle with proceed still high is the abort cycle.
   assign wdog_trip = (state_q == S_LOOP) && bus.proceed &&
                      (wdog_q == WW'(WDOG_LIMIT - 1));
`else
   assign wdog_trip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      sel_init = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      reg_load = 1'b0;
      done     = 1'b0;
      busy     = 1'b0;
      err      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.go) state_d = (bus.n > MAX_N_V) ? S_ERR : S_INIT;
         end
         S_INIT: begin
            sel_init = 1'b1;
            cnt_load = 1'b1;
            reg_load = 1'b1;
            busy     = 1'b1;
            state_d  = S_LOOP;
         end
         S_LOOP: begin
            busy = 1'b1;
            if (wdog_trip) begin
               state_d = S_ERR;
            end else begin
               // proceed=0 still multiplies: that is the final product step
               reg_load = 1'b1;
               cnt_en   = bus.proceed;
               if (!bus.proceed) state_d = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (!bus.go) state_d = S_IDLE;
         end
         S_ERR: begin
            err = 1'b1;
            if (!bus.go) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.sel_init = sel_init;
   assign bus.cnt_load = cnt_load;
   assign bus.cnt_en   = cnt_en;
   assign bus.reg_load = reg_load;
   assign bus.done     = done;
   assign bus.busy     = busy;
   assign bus.err      = err;
endmodule

// File: tb/tb_fact_ctrl.sv
// Directed bench for fact_ctrl with a behavioural factorial datapath model.
module tb_fact_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_p = 1'b0;
   logic [7:0] dp_cnt = 8'd0;
   logic [7:0] dp_reg = 8'd0;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   fact_ctrl_if #(.SIZE(8)) bus ();
   fact_ctrl #(.SIZE(8), .MAX_N(5), .WDOG_LIMIT(7)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Datapath: counter and product register, compare n > counter.
   assign bus.proceed = force_p ? 1'b1 : (bus.n > dp_cnt);
   always @(posedge clk) begin
      if (bus.cnt_load)    dp_cnt <= 8'd1;
      else if (bus.cnt_en) dp_cnt <= dp_cnt + 8'd1;
      if (bus.reg_load)    dp_reg <= bus.sel_init ? 8'd1 : 8'(dp_cnt * dp_reg);
   end

   function automatic logic [6:0] outs();
      return {bus.sel_init, bus.cnt_load, bus.cnt_en, bus.reg_load, bus.done, bus.busy, bus.err};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.go = 1'b0; bus.n = 8'd0;
      step(); step();
      rst = 1'b0;
      compared++;
      if (outs() !== 7'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %b expected %b", outs(), 7'b0);
      end
      step();
      compared++;
      if (outs() !== 7'b0) begin
         mismatched++;
         $display("FAIL idle_outputs: got %b expected %b", outs(), 7'b0);
      end
   endtask

   // Run one accepted operation, check latency, cnt_en count and result.
   task automatic run_op(input logic [7:0] nv, input logic [7:0] exp_res);
      int cyc = 0;
      int ens = 0;
      int lp  = (nv == 0) ? 1 : int'(nv);
      bus.n = nv; bus.go = 1'b1;
      do begin
         step(); cyc++;
         if (bus.cnt_en) ens++;
      end while (!bus.done && cyc < 40);
      compared++;
      if (cyc !== 2 + lp) begin
         mismatched++;
         $display("FAIL latency_n%0d: got %0d expected %0d", nv, cyc, 2 + lp);
      end
      compared++;
      if (ens !== lp - 1) begin
         mismatched++;
         $display("FAIL cnt_en_count_n%0d: got %0d expected %0d", nv, ens, lp - 1);
      end
      compared++;
      if (dp_reg !== exp_res || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         mismatched++;
         $display("FAIL result_n%0d: got %0d busy %b err %b expected %0d busy 0 err 0",
                  nv, dp_reg, bus.busy, bus.err, exp_res);
      end
      bus.go = 1'b0;
      step();
      compared++;
      if (outs() !== 7'b0) begin
         mismatched++;
         $display("FAIL done_release_n%0d: got %b expected %b", nv, outs(), 7'b0);
      end
   endtask

   task automatic test_n3();
      logic [2:0] en_seq = '0;
      bus.n = 8'd3; bus.go = 1'b1;
      step();
      compared++;
      if (outs() !== 7'b1101010) begin
         mismatched++;
         $display("FAIL init_outputs: got %b expected %b", outs(), 7'b1101010);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         en_seq[2-i] = bus.cnt_en;
         compared++;
         if ({bus.sel_init, bus.reg_load, bus.busy, bus.done} !== 4'b0110) begin
            mismatched++;
            $display("FAIL loop_outputs_c%0d: got %b expected %b", i,
                     {bus.sel_init, bus.reg_load, bus.busy, bus.done}, 4'b0110);
         end
      end
      compared++;
      if (en_seq !== 3'b110) begin
         mismatched++;
         $display("FAIL cnt_en_seq: got %b expected %b", en_seq, 3'b110);
      end
      step();
      compared++;
      if (bus.done !== 1'b1 || dp_reg !== 8'd6 || outs() !== 7'b0000100) begin
         mismatched++;
         $display("FAIL done_n3: got outs %b result %0d expected outs %b result 6",
                  outs(), dp_reg, 7'b0000100);
      end
      step(); step();
      compared++;
      if (bus.done !== 1'b1) begin
         mismatched++;
         $display("FAIL done_hold: got %b expected 1", bus.done);
      end
      bus.go = 1'b0;
      step();
      compared++;
      if (bus.done !== 1'b0) begin
         mismatched++;
         $display("FAIL done_drop: got %b expected 0", bus.done);
      end
   endtask

   task automatic test_small();
      run_op(8'd0, 8'd1);
      run_op(8'd1, 8'd1);
      run_op(8'd5, 8'd120);
      run_op(8'd4, 8'd24);
   endtask

   task automatic test_overflow(input logic [7:0] nv);
      logic strobes = 1'b0;
      bus.n = nv; bus.go = 1'b1;
      step();
      compared++;
      if (outs() !== 7'b0000001) begin
         mismatched++;
         $display("FAIL err_entry_n%0d: got %b expected %b", nv, outs(), 7'b0000001);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         strobes |= bus.reg_load | bus.cnt_load | bus.cnt_en | bus.done;
      end
      compared++;
      if (strobes !== 1'b0 || bus.err !== 1'b1) begin
         mismatched++;
         $display("FAIL err_hold_n%0d: got strobes %b err %b expected strobes 0 err 1",
                  nv, strobes, bus.err);
      end
      bus.go = 1'b0;
      step();
      compared++;
      if (bus.err !== 1'b0) begin
         mismatched++;
         $display("FAIL err_clear_n%0d: got %b expected 0", nv, bus.err);
      end
   endtask

   task automatic test_reset_mid_loop();
      logic saw_done = 1'b0;
      bus.n = 8'd4; bus.go = 1'b1;
      step(); step();
      rst = 1'b1;
      step();
      compared++;
      if (outs() !== 7'b0) begin
         mismatched++;
         $display("FAIL mid_loop_reset: got %b expected %b", outs(), 7'b0);
      end
      rst = 1'b0; bus.go = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         saw_done |= bus.done | bus.err | bus.busy;
      end
      compared++;
      if (saw_done !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_idle: got activity %b expected 0", saw_done);
      end
      run_op(8'd4, 8'd24);
   endtask

   task automatic test_go_toggle();
      int cyc = 0;
      bus.n = 8'd2; bus.go = 1'b1;
      step(); cyc++;
      bus.go = 1'b0;
      step(); cyc++;
      bus.go = 1'b1;
      while (!bus.done && cyc < 40) begin
         step(); cyc++;
      end
      compared++;
      if (cyc !== 4 || dp_reg !== 8'd2) begin
         mismatched++;
         $display("FAIL toggle_no_restart: got latency %0d result %0d expected 4 and 2", cyc, dp_reg);
      end
      for (int i = 0; i < 4; i++) step();
      compared++;
      if (outs() !== 7'b0000100) begin
         mismatched++;
         $display("FAIL toggle_done_hold: got %b expected %b", outs(), 7'b0000100);
      end
      bus.go = 1'b0;
      step();
      compared++;
      if (outs() !== 7'b0) begin
         mismatched++;
         $display("FAIL toggle_idle: got %b expected %b", outs(), 7'b0);
      end
   endtask

   task automatic test_stuck_proceed();
      force_p = 1'b1;
      bus.n = 8'd3; bus.go = 1'b1;
      step();
      bus.go = 1'b0;
`ifdef DP_CTRL_WDOG_EN
      for (int i = 0; i < 7; i++) begin
         step();
         compared++;
         if (bus.busy !== 1'b1 || {bus.cnt_en, bus.reg_load} !== ((i == 6) ? 2'b00 : 2'b11)) begin
            mismatched++;
            $display("FAIL wdog_loop_c%0d: got busy %b en/ld %b", i, bus.busy, {bus.cnt_en, bus.reg_load});
         end
      end
      step();
      compared++;
      if (outs() !== 7'b0000001) begin
         mismatched++;
         $display("FAIL wdog_abort: got %b expected %b", outs(), 7'b0000001);
      end
      step();
`else
      for (int i = 0; i < 20; i++) step();
      compared++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.cnt_en !== 1'b1) begin
         mismatched++;
         $display("FAIL stuck_loop: got busy %b err %b cnt_en %b expected 1 0 1",
                  bus.busy, bus.err, bus.cnt_en);
      end
`endif
      force_p = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      bus.go = 1'b0; bus.n = 8'd0;
      test_reset();
      test_n3();
      test_small();
      test_overflow(8'd6);
      test_overflow(8'd255);
      test_reset_mid_loop();
      test_go_toggle();
      test_stuck_proceed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Control unit for the factorial datapath. Sits directly upstream of `dp` and drives its `sel_init`, `cnt_load`, `cnt_en`, `reg_load` and `done` inputs.
- Consumes the datapath comparator output `proceed`, where `proceed` = (n > cnt_q) when `sel_init` = 0.
- Accepts a go/done handshake from the top level and rejects operands whose factorial overflows SIZE bits.

Parameters:
- SIZE, 8: width of operand n; matches the datapath SIZE.
- MAX_N, 5: largest n accepted (5! = 120 fits 8 bits; 6! does not).
- WDOG_LIMIT, 7: maximum LOOP cycles before watchdog abort. Used only with DP_CTRL_WDOG_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  start request, level-sensitive; sampled in IDLE only.
- n  input  SIZE  operand; must be held stable by the top level from go until done/err.
- proceed  input  1  datapath compare result (n > counter).
- sel_init  output  1  selects constant 1 into the datapath muxes.
- cnt_load  output  1  loads the datapath counter with 1.
- cnt_en  output  1  increments the datapath counter.
- reg_load  output  1  loads the datapath product register.
- done  output  1  result valid; datapath drives `result` while high.
- busy  output  1  high in INIT and LOOP.
- err  output  1  operand overflow (or watchdog abort).

Behaviour:
- States: IDLE, INIT, LOOP, DONE, ERR. Encoding is free. Outputs are decoded from state; `cnt_en` additionally depends on `proceed` (Mealy).
- Reset: rst=1 at a clock edge forces IDLE; all outputs are 0 from the following cycle. This holds from any state, including mid-LOOP; no partial done/err is emitted.
- IDLE:
  - All outputs 0.
  - go=1 and n <= MAX_N: next state INIT.
  - go=1 and n > MAX_N: next state ERR.
  - go=0: stay in IDLE.
- INIT (1 cycle): sel_init=1, cnt_load=1, reg_load=1, busy=1. Datapath counter becomes 1 and register becomes 1. Next state LOOP.
- LOOP: sel_init=0, reg_load=1, busy=1, cnt_en=proceed.
  - Each cycle: register <= counter*register; counter increments if proceed.
  - proceed=1: stay in LOOP.
  - proceed=0: this cycle performs the final multiply; next state DONE.
- LOOP duration: exactly max(n,1) cycles. n=0 and n=1 both take 1 cycle and yield result 1.
- go-to-done latency: 2 + max(n,1) cycles from the edge sampling go in IDLE to the first cycle with done=1.
- DONE: done=1, other outputs 0. Held while go=1 (minimum 1 cycle). go=0: next state IDLE.
- ERR: err=1, other outputs 0. No datapath strobes are issued. Held while go=1 (minimum 1 cycle). go=0: next state IDLE.
- go is ignored outside IDLE. A go already held high on return to IDLE starts a new operation only after it has been deasserted for at least 1 cycle: DONE and ERR exit only on go=0.
- Overflow check compares n (unsigned, SIZE bits) against MAX_N at the IDLE sampling edge only.
- done and err are never high together. busy and done are never high together.

Optional Feature:
- Macro: DP_CTRL_WDOG_EN.
- Defined:
  - A $clog2(WDOG_LIMIT+1)-bit counter clears in INIT and increments each LOOP cycle.
  - If LOOP is still active with proceed=1 after WDOG_LIMIT cycles, next state is ERR instead of LOOP; cnt_en and reg_load are 0 in that abort cycle.
  - This guards against a stuck proceed.
- Not defined: no counter exists; LOOP exits only on proceed=0.

Test Plan:
- Reset, then n=3, go=1 for one cycle then held: INIT for 1 cycle, LOOP for 3 cycles (cnt_en = 1,1,0), then done=1 and the datapath result is 6; done drops 1 cycle after go=0.
- n=0 and n=1: LOOP for 1 cycle, cnt_en=0, done with result 1; latency 3 cycles.
- n=5: result 120 after 7 cycles. n=6: IDLE goes to ERR next cycle, err=1, reg_load/cnt_load are never asserted, err clears after go=0.
- rst=1 during the 2nd LOOP cycle with n=4: all outputs 0 next cycle, state IDLE, no done; a new go with n=4 then completes with 24.
- go toggled during LOOP and held through DONE: no restart, done stays high until go=0; IDLE is reached only after go=0.
- DP_CTRL_WDOG_EN defined, proceed forced to 1 with n=3: after 7 LOOP cycles, ERR with err=1. Macro undefined: stays in LOOP indefinitely.
